gas_code_serializer: RTL

Transmit-side counterpart of the gas detector sensor: takes a 3-bit gas level code over a valid/ready handshake and serializes it onto a single-bit line (dout_bit), which drives the sensor's din input.
Used to stimulate the gas detector in system-level and loopback benches, and as the uplink source in a multi-sensor build.
All serial timing is derived from one clock with a per-bit cycle count.

---
 rtl/gas_code_serializer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gas_code_serializer.sv
// ============================================================================
// Module   : gas_code_serializer
// Brief    : Serializes a 3-bit gas level code onto a single-bit line:
//            START(1), level[2:0] MSB first, optional even parity, then
//            GAP_BITS idle-low bit periods. Each element lasts BIT_CYCLES clks.
// Option   : define GAS_SER_PARITY_EN to insert the even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gas_code_serializer #(
  parameter int BIT_CYCLES = 1,  // clocks per serial bit (1..255)
  parameter int GAP_BITS   = 2   // idle-low bit periods after each frame (1..15)
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [2:0] level,
  input  logic       valid,
  output logic       ready,
  output logic       dout_bit,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] c_last_cycle = 8'(BIT_CYCLES - 1);
  localparam logic [3:0] c_last_gap   = 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef GAS_SER_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_GAP    = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cycle, w_cycle_nxt;
  logic [1:0] r_bit,   w_bit_nxt;
  logic [3:0] r_gap,   w_gap_nxt;
  logic [2:0] r_hold,  w_hold_nxt;
  logic       w_dout_nxt;
  logic       w_done_nxt;
  logic       w_wrap;

  // Last clock of the current bit period.
  assign w_wrap = (r_cycle == c_last_cycle);

  // Handshake and status are decoded straight from the state register.
  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state != ST_IDLE);

  // Next-state logic; dout_bit is precomputed so the line changes on the same
  // edge as the element it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_cycle_nxt = r_cycle;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_hold_nxt  = r_hold;
    w_dout_nxt  = dout_bit;
    w_done_nxt  = 1'b0;

    if (r_state != ST_IDLE) begin
      w_cycle_nxt = w_wrap ? 8'd0 : r_cycle + 8'd1;
    end

    case (r_state)
      ST_IDLE: begin
        w_dout_nxt = 1'b0;
        if (valid) begin
          w_state_nxt = ST_START;
          w_hold_nxt  = level;
          w_cycle_nxt = 8'd0;
          w_bit_nxt   = 2'd0;
          w_gap_nxt   = 4'd0;
          w_dout_nxt  = 1'b1;
        end
      end

      ST_START: begin
        if (w_wrap) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 2'd0;
          w_dout_nxt  = r_hold[2];
        end
      end

      ST_DATA: begin
        if (w_wrap) begin
          case (r_bit)
            2'd0: begin
              w_bit_nxt  = 2'd1;
              w_dout_nxt = r_hold[1];
            end
            2'd1: begin
              w_bit_nxt  = 2'd2;
              w_dout_nxt = r_hold[0];
            end
            default: begin
              w_bit_nxt   = 2'd0;
`ifdef GAS_SER_PARITY_EN
              w_state_nxt = ST_PARITY;
              w_dout_nxt  = ^r_hold;
`else
              w_state_nxt = ST_GAP;
              w_gap_nxt   = 4'd0;
              w_dout_nxt  = 1'b0;
`endif
            end
          endcase
        end
      end

`ifdef GAS_SER_PARITY_EN
      ST_PARITY: begin
        if (w_wrap) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = 4'd0;
          w_dout_nxt  = 1'b0;
        end
      end
`endif

      ST_GAP: begin
        w_dout_nxt = 1'b0;
        if (w_wrap) begin
          if (r_gap == c_last_gap) begin
            w_state_nxt = ST_IDLE;
            w_gap_nxt   = 4'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_gap_nxt = r_gap + 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cycle_nxt = 8'd0;
        w_bit_nxt   = 2'd0;
        w_gap_nxt   = 4'd0;
        w_dout_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the line immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_cycle    <= 8'd0;
      r_bit      <= 2'd0;
      r_gap      <= 4'd0;
      r_hold     <= 3'd0;
      dout_bit   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cycle    <= w_cycle_nxt;
      r_bit      <= w_bit_nxt;
      r_gap      <= w_gap_nxt;
      r_hold     <= w_hold_nxt;
      dout_bit   <= w_dout_nxt;
      frame_done <= w_done_nxt;
    end
  end

endmodule

`default_nettype wire
